// File: rtl/keypad_pkg.sv
// Shared types and key-map for the 4x4 keypad scanner and its downstream debouncer.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned CODE_W   = 4;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    HELD
  } scan_state_t;

  // Row 3 carries the '*' and '#' keys, reported as E and F.
  function automatic logic [CODE_W-1:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [CODE_W-1:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle pulled-up lines).
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner: locks onto a single pressed key and reports its hex code
// until the key's row releases. No debouncing here.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 48000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row_n,
  output logic [3:0]        col_n,
  output logic              key_pressed,
  output logic [CODE_W-1:0] key_code
);

  localparam int unsigned     CNT_W   = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] row_s;

  sync2 #(
    .WIDTH(NUM_ROWS)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d    (row_n),
    .q    (row_s)
  );

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic              pressed_q, pressed_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [3:0] rows_low;
  logic       single_low;
  logic [1:0] low_idx;
  logic       cnt_done;

  assign rows_low   = ~row_s;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign single_low = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
  assign cnt_done   = (cnt_q == CNT_MAX);

  always_comb begin
    low_idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (rows_low[i]) low_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      pressed_q <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pressed_q <= pressed_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    pressed_d = pressed_q;
    code_d    = code_q;

    case (state_q)
      SETTLE: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SAMPLE: begin
        if (single_low) begin
          row_d     = low_idx;
          pressed_d = 1'b1;
          code_d    = key_map(low_idx, col_q);
          state_d   = HELD;
        end else begin
          // No key or an ambiguous multi-row hit: move on to the next column.
          col_d   = col_q + 2'd1;
          state_d = SETTLE;
        end
      end

      HELD: begin
        if (cnt_done) begin
          cnt_d = '0;
          // Only the locked row is watched; other rows are ignored while held.
          if (row_s[row_q]) begin
            pressed_d = 1'b0;
            col_d     = col_q + 2'd1;
            state_d   = SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign col_n       = ~(4'b0001 << col_q);
  assign key_pressed = pressed_q;
  assign key_code    = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad-matrix model driving row_n from col_n.
module tb_keypad_scanner;

  localparam int unsigned SETTLE = 4;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_pressed;
  logic [3:0] key_code;

  // keys[r*4 + c] set means the key at (row r, col c) is held down.
  logic [15:0] keys;
  logic        raw_mode;
  logic [3:0]  raw_row;
  logic [3:0]  matrix_row;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_scanner #(
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_pressed(key_pressed),
    .key_code   (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    matrix_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[r*4 +: 4] & ~col_n)) matrix_row[r] = 1'b0;
    end
  end

  assign row_n = raw_mode ? raw_row : matrix_row;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_press(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (key_pressed) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max_cyc, output int n);
    n = 0;
    while (key_pressed && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bit ok;
    int n;
    bit any_press;
    bit held_ok;
    int changes;
    logic [3:0] prev_col;
    logic [3:0] exp_col;

    reset    = 1'b1;
    keys     = '0;
    raw_mode = 1'b0;
    raw_row  = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("reset col_n", 32'(col_n), 32'hE);
    check("reset key_pressed", 32'(key_pressed), 32'h0);
    check("reset key_code", 32'(key_code), 32'h0);

    // Idle sweep: 5 cycles per column, wrapping 3 -> 0.
    reset     = 1'b0;
    any_press = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((i / 5) % 4));
      check($sformatf("idle col_n[%0d]", i), 32'(col_n), 32'(exp_col));
      if (key_pressed) any_press = 1'b1;
    end
    check("idle no press", 32'(any_press), 32'h0);

    // Single press of '6' (row 1, col 2).
    keys[1*4 + 2] = 1'b1;
    wait_press(60, ok);
    check("press6 lock", 32'(ok), 32'h1);
    check("press6 code", 32'(key_code), 32'h6);
    check("press6 col_n", 32'(col_n), 32'hB);
    held_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (col_n !== 4'hB || key_pressed !== 1'b1) held_ok = 1'b0;
    end
    check("press6 col frozen", 32'(held_ok), 32'h1);

    // Release.
    keys = '0;
    wait_release(10, n);
    check("release6 fell", 32'(key_pressed), 32'h0);
    check("release6 within 6", 32'(n <= 6), 32'h1);
    check("release6 code held", 32'(key_code), 32'h6);
    check("release6 next col", 32'(col_n), 32'h7);

    // Ghost: two rows low on every column never locks, scanning carries on.
    raw_mode  = 1'b1;
    raw_row   = 4'b1100;
    any_press = 1'b0;
    changes   = 0;
    prev_col  = col_n;
    repeat (40) begin
      @(negedge clk);
      if (key_pressed) any_press = 1'b1;
      if (col_n != prev_col) changes++;
      prev_col = col_n;
    end
    check("ghost no press", 32'(any_press), 32'h0);
    check("ghost col steps", 32'(changes), 32'd8);
    raw_row = 4'hF;
    repeat (4) @(negedge clk);
    raw_mode = 1'b0;

    // Corner key 'D' (row 3, col 3).
    keys[3*4 + 3] = 1'b1;
    wait_press(60, ok);
    check("keyD lock", 32'(ok), 32'h1);
    check("keyD code", 32'(key_code), 32'hD);
    check("keyD col_n", 32'(col_n), 32'h7);
    keys = '0;
    wait_release(10, n);
    check("keyD released", 32'(key_pressed), 32'h0);
    check("keyD wrap col", 32'(col_n), 32'hE);

    // Second key in the held column is ignored.
    keys[0*4 + 0] = 1'b1;
    wait_press(60, ok);
    check("key1 lock", 32'(ok), 32'h1);
    check("key1 code", 32'(key_code), 32'h1);
    keys[2*4 + 0] = 1'b1;
    held_ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (key_code !== 4'h1 || key_pressed !== 1'b1) held_ok = 1'b0;
    end
    check("key1 ignores row2", 32'(held_ok), 32'h1);
    keys[0*4 + 0] = 1'b0;
    wait_release(10, n);
    check("key1 row0 release", 32'(key_pressed), 32'h0);
    check("key1 release within 6", 32'(n <= 6), 32'h1);
    check("key1 code after release", 32'(key_code), 32'h1);
    keys = '0;
    repeat (30) @(negedge clk);

    // Reset mid-hold.
    keys[1*4 + 2] = 1'b1;
    wait_press(60, ok);
    check("rst lock", 32'(ok), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    keys  = '0;
    check("rst key_pressed", 32'(key_pressed), 32'h0);
    check("rst key_code", 32'(key_code), 32'h0);
    check("rst col_n", 32'(col_n), 32'hE);
    repeat (5) @(negedge clk);
    check("rst rescan col_n", 32'(col_n), 32'hD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
